// File: rtl/debounce_pkg.sv
// Shared types and constants for the switch debouncer.
// Provides the per-channel FSM state encoding and the minimum stable count.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        PEND_HIGH = 2'd1,
        ST_HIGH   = 2'd2,
        PEND_LOW  = 2'd3
    } deb_state_t;

    localparam int MIN_STABLE_CYCLES = 2;

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debounce channel: 2-flop synchroniser, stability FSM and
// counter, registered clean level plus one-cycle rise/fall pulses.
// Ports: clk, rst (async, active-high), raw_i (async in),
//        level_o, rise_o, fall_o (all registered).
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // Values below the legal minimum are clamped rather than
    // producing a zero-width counter.
    localparam int SC = (STABLE_CYCLES < MIN_STABLE_CYCLES) ?
                        MIN_STABLE_CYCLES : STABLE_CYCLES;
    localparam int CW = $clog2(SC);
    localparam logic [CW-1:0] TERM = CW'(SC - 1);

    logic          r_sync1;
    logic          r_sync2;
    deb_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;

    deb_state_t    w_state;
    logic [CW-1:0] w_cnt;
    logic          w_level;
    logic          w_rise;
    logic          w_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= raw_i;
            r_sync2 <= r_sync1;
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_level <= w_level;
            r_rise  <= w_rise;
            r_fall  <= w_fall;
        end
    end

    // In the pending states the input compare is checked before the
    // terminal count, so a bounce on the final cycle is still rejected.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_level = r_level;
        w_rise  = 1'b0;
        w_fall  = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (r_sync2) begin
                    w_state = PEND_HIGH;
                    w_cnt   = '0;
                end
            end
            PEND_HIGH: begin
                if (!r_sync2) begin
                    w_state = ST_LOW;
                    w_cnt   = '0;
                end else if (r_cnt == TERM) begin
                    w_state = ST_HIGH;
                    w_cnt   = '0;
                    w_level = 1'b1;
                    w_rise  = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_HIGH: begin
                if (!r_sync2) begin
                    w_state = PEND_LOW;
                    w_cnt   = '0;
                end
            end
            PEND_LOW: begin
                if (r_sync2) begin
                    w_state = ST_HIGH;
                    w_cnt   = '0;
                end else if (r_cnt == TERM) begin
                    w_state = ST_LOW;
                    w_cnt   = '0;
                    w_level = 1'b0;
                    w_fall  = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = ST_LOW;
                w_cnt   = '0;
            end
        endcase
    end

    assign level_o = r_level;
    assign rise_o  = r_rise;
    assign fall_o  = r_fall;

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer: WIDTH independent debounce channels
// plus a registered any-edge flag one cycle behind the pulses.
// Ports: clk, rst (async, active-high), raw_i[WIDTH], level_o, rise_o,
//        fall_o [WIDTH], any_edge_o.
module switch_debouncer #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             any_edge_o
);

    logic r_any_edge;

    for (genvar k = 0; k < WIDTH; k++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (raw_i[k]),
            .level_o(level_o[k]),
            .rise_o (rise_o[k]),
            .fall_o (fall_o[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_any_edge <= 1'b0;
        end else begin
            r_any_edge <= |(rise_o | fall_o);
        end
    end

    assign any_edge_o = r_any_edge;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed table-driven bench for switch_debouncer (WIDTH=2, STABLE=4).
// Each vector drives inputs for one edge, then checks outputs after it.
module tb_switch_debouncer;

    logic       clk;
    logic       rst;
    logic [1:0] raw_i;
    logic [1:0] level_o;
    logic [1:0] rise_o;
    logic [1:0] fall_o;
    logic       any_edge_o;

    int n_vec;
    int n_err;

    typedef struct {
        logic       rst;
        logic [1:0] raw;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    switch_debouncer #(
        .WIDTH        (2),
        .STABLE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raw_i     (raw_i),
        .level_o   (level_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .any_edge_o(any_edge_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [1:0] raw,
                       input logic [1:0] lvl, input logic [1:0] ri,
                       input logic [1:0] fa, input logic an);
        vec_t v;
        v.rst = r;
        v.raw = raw;
        v.exp = {lvl, ri, fa, an};
        tbl.push_back(v);
    endtask

    task automatic add_n(input int n, input logic r,
                         input logic [1:0] raw, input logic [1:0] lvl);
        for (int i = 0; i < n; i++) add(r, raw, lvl, 2'b00, 2'b00, 1'b0);
    endtask

    // Drive one vector, let one rising edge pass, compare 1 time unit later.
    task automatic apply(input string name, input logic r,
                         input logic [1:0] raw, input logic [6:0] exp);
        logic [6:0] got;
        rst   = r;
        raw_i = raw;
        @(posedge clk);
        #1;
        got = {level_o, rise_o, fall_o, any_edge_o};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got lvl=%b rise=%b fall=%b any=%b, want lvl=%b rise=%b fall=%b any=%b",
                     name, n_vec, got[6:5], got[4:3], got[2:1], got[0],
                     exp[6:5], exp[4:3], exp[2:1], exp[0]);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        raw_i = 2'b11;

        // Reset with inputs high, then release: rise at E0+6.
        add_n(2, 1'b1, 2'b11, 2'b00);
        add_n(6, 1'b0, 2'b11, 2'b00);
        add(1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0);
        add(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1);
        add(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
        // Re-reset, then a clean step on channel 0.
        add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        add_n(6, 1'b0, 2'b01, 2'b00);
        add(1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1'b0);
        add(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1);
        add(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        // Three-cycle glitch on channel 1 is discarded.
        add_n(3, 1'b0, 2'b11, 2'b01);
        add_n(8, 1'b0, 2'b01, 2'b01);
        // Simultaneous opposite transitions.
        add_n(6, 1'b0, 2'b10, 2'b01);
        add(1'b0, 2'b10, 2'b10, 2'b10, 2'b01, 1'b0);
        add(1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 1'b1);
        add(1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
        // Channel 1 falls back low.
        add_n(6, 1'b0, 2'b00, 2'b10);
        add(1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0);
        add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

        foreach (tbl[i]) apply("table", tbl[i].rst, tbl[i].raw, tbl[i].exp);

        // Bounce exactly at the terminal count: high 4, low 1, high on.
        // The single rise lands 6 edges after the final rising sample.
        for (int i = 0; i < 16; i++) begin
            logic [1:0] raw;
            logic [6:0] exp;
            raw = (i == 4) ? 2'b00 : 2'b01;
            exp = {1'b0, (i >= 11), 1'b0, (i == 11), 2'b00, (i == 12)};
            apply("bounce_tc", 1'b0, raw, exp);
        end

        // Reset in the middle of a pending rise.
        apply("midpend_rst0", 1'b1, 2'b00, 7'd0);
        for (int i = 0; i < 3; i++) apply("midpend_pre", 1'b0, 2'b01, 7'd0);
        apply("midpend_rst1", 1'b1, 2'b01, 7'd0);
        for (int i = 0; i < 10; i++) begin
            logic [6:0] exp;
            exp = {1'b0, (i >= 6), 1'b0, (i == 6), 2'b00, (i == 7)};
            apply("midpend_post", 1'b0, 2'b01, exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
